// File: rtl/tsc_sample_ctrl.sv
// tsc_sample_ctrl: periodic ADC sampling controller with a circular
// pre/post-trigger capture buffer and registered readout port.
module tsc_sample_ctrl #(
   parameter int DEPTH      = 32,
   parameter int SAMPLE_DIV = 16,
   parameter int REQ_W      = 2,
   parameter int SETTLE     = 1,
   parameter int TIMEOUT    = 64,
   parameter int POST_CNT   = 8,
   localparam int AW        = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          arm,
   input  logic          abort,
   input  logic [7:0]    thresh,
   output logic          adc_req,
   output logic          adc_rst,
   input  logic          adc_rdy,
   input  logic [7:0]    adc_dat,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [AW-1:0] trig_pos,
   output logic [AW:0]   n_valid,
   input  logic [AW-1:0] rd_addr,
   output logic [7:0]    rd_data
);

   localparam int CW = 16;

   localparam logic [3:0] S_IDLE   = 4'd0;
   localparam logic [3:0] S_ARST   = 4'd1;
   localparam logic [3:0] S_REQ    = 4'd2;
   localparam logic [3:0] S_WAIT   = 4'd3;
   localparam logic [3:0] S_SETTLE = 4'd4;
   localparam logic [3:0] S_STORE  = 4'd5;
   localparam logic [3:0] S_GAP    = 4'd6;
   localparam logic [3:0] S_DONE   = 4'd7;
   localparam logic [3:0] S_ERR    = 4'd8;

   localparam logic [CW-1:0] ARST_LAST   = CW'(1);
   localparam logic [CW-1:0] REQ_LAST    = CW'(REQ_W - 1);
   localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
   localparam logic [CW-1:0] TMO_LAST    = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] DIV_LAST    = CW'(SAMPLE_DIV - 1);
   localparam logic [AW:0]   NV_MAX      = (AW+1)'(DEPTH);
   localparam logic [AW:0]   POST_LAST   = (AW+1)'(POST_CNT - 1);

   logic [3:0]    state;
   logic [3:0]    state_nx;
   logic          rdy_m;
   logic          rdy_s;
   logic [CW-1:0] st_cnt;
   logic [CW-1:0] div_cnt;
   logic [7:0]    thresh_q;
   logic [AW-1:0] wptr;
   logic [AW:0]   nval_q;
   logic          trig_seen;
   logic [AW:0]   post_q;
   logic [AW-1:0] trig_q;
   logic [7:0]    mem [DEPTH];
   logic [7:0]    rd_q;
   logic [AW-1:0] oldest;
   logic [AW-1:0] rd_idx;
   logic          idle_like;
   logic          arm_ok;
   logic          store_en;
   logic          hit;
   logic          post_done;

   assign idle_like = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR);
   assign arm_ok    = arm && !abort && idle_like;
   assign store_en  = (state == S_STORE) && !abort;
   assign hit       = !trig_seen && (adc_dat > thresh_q);

   // Capture finishes on the trigger sample itself when no post samples are wanted.
   assign post_done = (hit && (POST_CNT == 0)) ||
                      (trig_seen && (POST_CNT != 0) && (post_q == POST_LAST));

   // Two-flop synchroniser for the asynchronous ready level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdy_m <= 1'b0;
         rdy_s <= 1'b0;
      end else begin
         rdy_m <= adc_rdy;
         rdy_s <= rdy_m;
      end
   end

   // Next-state decode; abort overrides everything, including a coincident arm.
   always_comb begin
      state_nx = state;
      if (abort) begin
         state_nx = S_IDLE;
      end else begin
         case (state)
            S_IDLE, S_DONE, S_ERR: begin
               if (arm) state_nx = S_ARST;
            end
            S_ARST: begin
               if (st_cnt == ARST_LAST) state_nx = S_REQ;
            end
            S_REQ: begin
               if (st_cnt == REQ_LAST) state_nx = S_WAIT;
            end
            S_WAIT: begin
               if (rdy_s)
                  state_nx = (SETTLE == 0) ? S_STORE : S_SETTLE;
               else if (st_cnt == TMO_LAST)
                  state_nx = S_ERR;
            end
            S_SETTLE: begin
               if (st_cnt == SETTLE_LAST) state_nx = S_STORE;
            end
            S_STORE: begin
               if (post_done)
                  state_nx = S_DONE;
               else if (div_cnt >= DIV_LAST)
                  state_nx = S_REQ;
               else
                  state_nx = S_GAP;
            end
            S_GAP: begin
               if (div_cnt >= DIV_LAST) state_nx = S_REQ;
            end
            default: state_nx = S_IDLE;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   // Cycles spent in the current state, restarting on every state change.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         st_cnt <= '0;
      else if (state_nx != state)
         st_cnt <= '0;
      else if (st_cnt != '1)
         st_cnt <= st_cnt + 1'b1;
   end

   // Cycles since the last REQ entry; GAP pads until the sample period elapses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         div_cnt <= '0;
      else if ((state_nx == S_REQ) && (state != S_REQ))
         div_cnt <= '0;
      else if (div_cnt != '1)
         div_cnt <= div_cnt + 1'b1;
   end

   // Buffer bookkeeping: pointers, fill level, trigger and post-trigger count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         thresh_q  <= '0;
         wptr      <= '0;
         nval_q    <= '0;
         trig_seen <= 1'b0;
         post_q    <= '0;
         trig_q    <= '0;
      end else if (arm_ok) begin
         thresh_q  <= thresh;
         wptr      <= '0;
         nval_q    <= '0;
         trig_seen <= 1'b0;
         post_q    <= '0;
         trig_q    <= '0;
      end else if (store_en) begin
         wptr <= wptr + 1'b1;
         if (nval_q != NV_MAX) nval_q <= nval_q + 1'b1;
         if (hit) begin
            trig_seen <= 1'b1;
            trig_q    <= wptr;
            post_q    <= '0;
         end else if (trig_seen) begin
            post_q <= post_q + 1'b1;
         end
      end
   end

   // Sample storage; contents are not reset.
   always_ff @(posedge clk) begin
      if (store_en) mem[wptr] <= adc_dat;
   end

   // Once the buffer has wrapped, the oldest entry is the next one to be overwritten.
   assign oldest = nval_q[AW] ? wptr : '0;
   assign rd_idx = oldest + rd_addr;

   // Registered readout relative to the oldest sample.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) rd_q <= '0;
      else     rd_q <= mem[rd_idx];
   end

   assign adc_req  = (state == S_REQ) && !abort;
   assign adc_rst  = (state == S_ARST);
   assign busy     = !idle_like;
   assign done     = (state == S_DONE);
   assign err      = (state == S_ERR);
   assign trig_pos = trig_q;
   assign n_valid  = nval_q;
   assign rd_data  = rd_q;

endmodule
